// File: rtl/spi_engine.sv
// SPI master byte engine, mode 0, MSB first, with a ce-qualified SCLK divider.
// One byte per write; dsr flags idle/ready, overrun flags writes dropped while busy.
module spi_engine #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren,
  input  logic [7:0] tx_i,
  input  logic       cs_n_i,
  output logic       dsr,
  output logic [7:0] rx_o,
  output logic       overrun,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_t     r_state,   w_state;
  logic [7:0] r_div,     w_div;
  logic [2:0] r_bit,     w_bit;
  logic [7:0] r_shreg,   w_shreg;
  logic       r_sample,  w_sample;
  logic [7:0] r_rx,      w_rx;
  logic       r_sclk,    w_sclk;
  logic       r_overrun, w_overrun;
  logic       r_ss_n,    w_ss_n;
  logic [7:0] w_shifted;

  assign w_shifted = {r_shreg[6:0], r_sample};

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    w_state   = r_state;
    w_div     = r_div;
    w_bit     = r_bit;
    w_shreg   = r_shreg;
    w_sample  = r_sample;
    w_rx      = r_rx;
    w_sclk    = r_sclk;
    w_overrun = r_overrun;
    w_ss_n    = r_ss_n;

    if (ce) begin
      w_ss_n = cs_n_i;
      // Any write outside IDLE, including on the completion edge, is dropped.
      if (wren && r_state != S_IDLE) w_overrun = 1'b1;

      unique case (r_state)
        S_IDLE: begin
          w_sclk = 1'b0;
          if (wren) begin
            w_shreg   = tx_i;
            w_div     = '0;
            w_bit     = '0;
            w_overrun = 1'b0;
            w_state   = S_LO;
          end
        end
        S_LO: begin
          if (r_div == DIV_LAST) begin
            w_sclk   = 1'b1;
            w_sample = miso;
            w_div    = '0;
            w_state  = S_HI;
          end else begin
            w_div = r_div + 8'd1;
          end
        end
        S_HI: begin
          if (r_div == DIV_LAST) begin
            w_sclk  = 1'b0;
            w_shreg = w_shifted;
            w_bit   = r_bit + 3'd1;
            w_div   = '0;
            if (r_bit == 3'd7) begin
              w_rx    = w_shifted;
              w_state = S_IDLE;
            end else begin
              w_state = S_LO;
            end
          end else begin
            w_div = r_div + 8'd1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous and overrides ce, so an abort never needs an enabled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_shreg   <= 8'hFF;
      r_sample  <= 1'b0;
      r_rx      <= 8'hFF;
      r_sclk    <= 1'b0;
      r_overrun <= 1'b0;
      r_ss_n    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      r_state   <= w_state;
      r_div     <= w_div;
      r_bit     <= w_bit;
      r_shreg   <= w_shreg;
      r_sample  <= w_sample;
      r_rx      <= w_rx;
      r_sclk    <= w_sclk;
      r_overrun <= w_overrun;
      r_ss_n    <= w_ss_n;
    end
  end

  assign dsr     = (r_state == S_IDLE);
  assign rx_o    = r_rx;
  assign overrun = r_overrun;
  assign sclk    = r_sclk;
  assign mosi    = r_shreg[7];
  assign ss_n    = r_ss_n;

endmodule
